// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier datapaths.
//   state_t       : FSM state of the sequential shift-add multiplier
//   WIDTH_DEFAULT : default operand width in bits
package mult_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage : mult_pkg

// File: rtl/pp_row_adder.sv
// One partial-product row: (mcand AND mbit) ripple-added onto hi.
// Same cell structure as a row of the unrolled array multiplier.
// Ports:
//   mcand [WIDTH-1:0] : multiplicand
//   mbit              : current multiplier bit
//   hi    [WIDTH-1:0] : running upper half of the product
//   s     [WIDTH:0]   : row sum, carry-out in s[WIDTH]
module pp_row_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] mcand,
    input  logic             mbit,
    input  logic [WIDTH-1:0] hi,
    output logic [WIDTH:0]   s
);

    logic [WIDTH:0] carry;
    logic [WIDTH-1:0] pp;

    assign pp = mcand & {WIDTH{mbit}};

    always_comb begin
        carry    = '0;
        s        = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            s[i]       = hi[i] ^ pp[i] ^ carry[i];
            carry[i+1] = (hi[i] & pp[i]) | (hi[i] & carry[i]) | (pp[i] & carry[i]);
        end
        s[WIDTH] = carry[WIDTH];
    end

endmodule : pp_row_adder

// File: rtl/seq_array_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier, one partial-product row per
// clock (shift-add). Area-reduced alternative to the unrolled array.
// Ports:
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake (a, b)
//   a, b [WIDTH-1:0]     : multiplicand, multiplier
//   out_valid / out_ready: product handshake
//   product [2*WIDTH-1:0]: a*b, valid only while out_valid is high
//   busy                 : high while an operation is in RUN or DONE
module seq_array_multiplier
    import mult_pkg::*;
#(
    parameter  int WIDTH = WIDTH_DEFAULT,
    localparam int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   s;

    // lo doubles as the multiplier shift register: its LSB is the bit for
    // the current row, and vacated top bits collect the low product bits.
    pp_row_adder #(.WIDTH(WIDTH)) u_row (
        .mcand (mcand),
        .mbit  (lo[0]),
        .hi    (hi),
        .s     (s)
    );

    assign product = {hi, lo};

    // Handshake/status outputs are registered alongside state so they
    // always agree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a;
                        lo       <= b;
                        hi       <= '0;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    hi <= s[WIDTH:1];
                    lo <= {s[0], lo[WIDTH-1:1]};
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule : seq_array_multiplier
